// File: rtl/mat_loader.sv
// mat_loader: assembles two packed 3x3 matrices of 4-bit elements from a serial beat stream
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   in_valid/in_ready  input beat handshake; in_data is one element in row-major order
//   in_first           marks element 0 of matrix A; realigns the loader if it arrives mid-pair
//   out_valid/out_ready  pair handshake; a_out/b_out are held while out_valid is high
//   a_out, b_out       packed matrices, element k at bits [35-4k:32-4k]
//   sync_err           sticky flag set by any realignment, cleared only by reset
module mat_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_data,
  input  logic        in_first,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] a_out,
  output logic [35:0] b_out,
  output logic        sync_err
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, slot;
  logic [5:0] idx;
  logic acc, resync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    in_ready = state != FULL;
    out_valid = state == FULL;
    acc = in_valid && in_ready;
    resync = acc && in_first && !(state == LOAD_A && cnt == 4'd0);
    slot = resync ? 4'd0 : cnt;
    idx = 6'd35 - {slot, 2'b00};
    state_n = state;
    cnt_n = cnt;
    if (resync) begin
      state_n = LOAD_A;
      cnt_n = 4'd1;
    end else if (acc) begin
      cnt_n = (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
      if (cnt == 4'd8) state_n = (state == LOAD_A) ? LOAD_B : FULL;
    end else if (state == FULL && out_ready) begin
      state_n = LOAD_A;
    end
  end
  // a resync beat always lands in A slot 0, even when it arrives during LOAD_B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= 36'd0;
      b_out <= 36'd0;
      sync_err <= 1'b0;
    end else begin
      if (acc && (state == LOAD_A || resync)) a_out[idx -: 4] <= in_data;
      else if (acc) b_out[idx -: 4] <= in_data;
      sync_err <= sync_err | resync;
    end
  end
endmodule

// File: tb/tb_mat_loader.sv
// tb_mat_loader: directed self-checking bench for mat_loader with a beat-count reference model
module tb_mat_loader;
  logic clk = 1'b0, rst_n, in_valid, in_first, out_ready;
  logic [3:0] in_data;
  logic in_ready, out_valid, sync_err;
  logic [35:0] a_out, b_out;
  int passed = 0, total = 0;
  bit go = 0;
  mat_loader dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_first(in_first), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .sync_err(sync_err));
  always #5 clk = ~clk;
  int n = 0;
  bit full = 0, serr = 0;
  logic [3:0] ma [9], mb [9];
  initial for (int i = 0; i < 9; i++) begin ma[i] = 4'd0; mb[i] = 4'd0; end
  // reference: the pair is just the last 18 accepted beats since start or realignment
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; full = 0; serr = 0;
    end else if (full) begin
      if (out_ready) full = 0;
    end else if (in_valid) begin
      if (in_first && n != 0) begin serr = 1; n = 0; end
      if (n < 9) ma[n] = in_data; else mb[n-9] = in_data;
      n++;
      if (n == 18) begin full = 1; n = 0; end
    end
  end
  function automatic logic [35:0] pack(input logic [3:0] m [9]);
    logic [35:0] r = 36'd0;
    for (int i = 0; i < 9; i++) r = {r[31:0], m[i]};
    return r;
  endfunction
  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  always @(negedge clk) if (go) begin
    chk("out_valid", {35'd0, out_valid}, {35'd0, full});
    chk("in_ready", {35'd0, in_ready}, {35'd0, !full});
    chk("sync_err", {35'd0, sync_err}, {35'd0, serr});
    if (full) begin
      chk("a_out", a_out, pack(ma));
      chk("b_out", b_out, pack(mb));
    end
  end
  task automatic send(input logic [3:0] d, input logic f);
    int t = 0;
    in_valid = 1; in_data = d; in_first = f;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t == 50) chk("send_timeout", 36'd1, 36'd0);
    @(posedge clk); #1;
    in_valid = 0; in_first = 0;
  endtask
  task automatic release_pair();
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    chk("release_valid", {35'd0, out_valid}, 36'd0);
    chk("release_ready", {35'd0, in_ready}, 36'd1);
  endtask
  initial begin
    logic [3:0] s;
    rst_n = 1; in_valid = 0; in_first = 0; in_data = 4'd0; out_ready = 0;
    #2 rst_n = 0;
    #1 chk("rst_a", a_out, 36'd0);
    chk("rst_b", b_out, 36'd0);
    chk("rst_valid", {35'd0, out_valid}, 36'd0);
    chk("rst_ready", {35'd0, in_ready}, 36'd1);
    #3 rst_n = 1;
    go = 1;
    for (int i = 1; i <= 9; i++) send(4'(i), i == 1);
    for (int i = 0; i < 8; i++) send(4'hF, 0);
    chk("v_before_18", {35'd0, out_valid}, 36'd0);
    send(4'hF, 0);
    chk("v_after_18", {35'd0, out_valid}, 36'd1);
    chk("straight_a", a_out, 36'h123456789);
    chk("straight_b", b_out, 36'hFFFFFFFFF);
    chk("straight_err", {35'd0, sync_err}, 36'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_ready", {35'd0, in_ready}, 36'd0);
      chk("bp_a", a_out, 36'h123456789);
    end
    release_pair();
    for (int i = 0; i < 18; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 send(i < 9 ? 4'h7 : 4'h8, 0);
    end
    chk("gap_a", a_out, 36'h777777777);
    chk("gap_b", b_out, 36'h888888888);
    release_pair();
    for (int i = 0; i < 9; i++) send(4'h3, 0);
    for (int i = 0; i < 3; i++) send(4'h2, 0);
    send(4'h5, 1);
    chk("resync_err", {35'd0, sync_err}, 36'd1);
    chk("resync_valid", {35'd0, out_valid}, 36'd0);
    for (int i = 1; i <= 8; i++) send(4'(i), 0);
    for (int i = 0; i < 9; i++) send(4'hA, 0);
    chk("resync_a", a_out, 36'h512345678);
    chk("resync_b", b_out, 36'hAAAAAAAAA);
    chk("resync_a0", {32'd0, a_out[35:32]}, 36'h5);
    release_pair();
    for (int i = 0; i < 12; i++) send(4'h6, 0);
    #2 rst_n = 0;
    #1 chk("mid_rst_a", a_out, 36'd0);
    chk("mid_rst_b", b_out, 36'd0);
    chk("mid_rst_err", {35'd0, sync_err}, 36'd0);
    chk("mid_rst_ready", {35'd0, in_ready}, 36'd1);
    #2 rst_n = 1;
    for (int i = 0; i < 18; i++) send(i < 9 ? 4'h7 : 4'h1, 0);
    chk("add_a", a_out, 36'h777777777);
    chk("add_b", b_out, 36'h111111111);
    for (int k = 0; k < 9; k++) begin
      s = a_out[35-4*k -: 4] + b_out[35-4*k -: 4];
      chk("adder_sum", {20'd0, {12{s[3]}}, s}, 36'h0FFF8);
    end
    release_pair();
    repeat (2) @(posedge clk);
    go = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mat_loader.md
# mat_loader

Upstream feeder for the 3x3 matrix adder. It accepts a serial stream of 4-bit signed elements over a valid/ready handshake and assembles two packed 3x3 matrices, A then B. It presents both as 36-bit packed words with a valid/ready output handshake, and holds them stable until the adder side consumes them. Element packing matches the adder's input format exactly, so `a_out`/`b_out` wire straight to its `a`/`b` ports.

## Interface
- No parameters. Element width 4, matrix 3x3, packed width 36 are fixed by the adder.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` beat is valid.
- `in_data` in 4: signed element, row-major order.
- `in_first` in 1: marks the beat as element 0 of matrix A.
- `in_ready` out 1: loader can accept a beat.
- `out_valid` out 1: `a_out`/`b_out` hold a complete pair.
- `out_ready` in 1: consumer accepts the pair.
- `a_out` out 36: packed matrix A.
- `b_out` out 36: packed matrix B.
- `sync_err` out 1: sticky flag for a resync event.

## Operation
- States:
  - LOAD_A: collecting A.
  - LOAD_B: collecting B.
  - FULL: pair presented.
- Element counter `cnt`, range 0..8.
- An input beat is accepted when `in_valid && in_ready`.
- `in_ready` = (state != FULL). It is combinational from state and does not depend on `in_valid`.
- Packing: element k (k = 0..8, row r = k/3, col c = k%3) goes to bits [35-4k : 32-4k].
  - Element 0 therefore lands in [35:32]; element 8 lands in [3:0].
  - Data is stored unmodified; sign handling belongs to the adder.
- LOAD_A:
  - An accepted beat writes `a_out` slot `cnt`.
  - When `cnt == 8`, go to LOAD_B and set `cnt = 0`. Otherwise `cnt++`.
- LOAD_B:
  - An accepted beat writes `b_out` slot `cnt`.
  - When `cnt == 8`, go to FULL, set `cnt = 0`, and set `out_valid = 1`.
- FULL:
  - `a_out`, `b_out` and `out_valid` are held.
  - When `out_valid && out_ready`, clear `out_valid` and go to LOAD_A. The next beat can be accepted in the following cycle.
- Resync:
  - Applies to an accepted beat with `in_first = 1` while the loader is not at (LOAD_A, `cnt == 0`).
  - The beat is written as A element 0, the state becomes LOAD_A, `cnt` becomes 1, and `sync_err` is set.
  - Partial contents of `b_out` are stale until overwritten.
- `in_first` at (LOAD_A, `cnt == 0`) is normal and has no side effect.
- `in_first = 0` at (LOAD_A, `cnt == 0`) is accepted normally as element 0, so `in_first` is optional.
- `sync_err` clears only on reset.
- While the loader is in LOAD_A or LOAD_B, `a_out`/`b_out` may change; their values are defined only while `out_valid = 1`.

## Timing
- Reset values:
  - state LOAD_A, `cnt = 0`
  - `a_out = 0`, `b_out = 0`
  - `out_valid = 0`, `sync_err = 0`
  - `in_ready = 1`
- Reset takes effect immediately, with no clock needed, including in the middle of a load or while in FULL. Any partial pair is discarded.
- All state, counter, data and flag updates occur on the rising edge of `clk`.
- `out_valid` rises in the cycle after the 18th accepted beat.
- Minimum period per pair is 19 cycles: 18 load cycles plus 1 FULL cycle with `out_ready` high.
- Back-pressure: `out_ready` low holds FULL indefinitely, and `in_ready` stays 0 throughout.
- `in_valid` gaps stall `cnt` with no data change.
- No combinational path from `in_valid`, `in_data` or `out_ready` to any output.

## Test plan
- **Reset, then straight load.** Feed A = 1..9 and B = -1 (4'hF) ×9, with `in_valid` held high.
  - `out_valid` goes high in the cycle after beat 18.
  - `a_out` = 36'h123456789, `b_out` = 36'hFFFFFFFFF, `sync_err = 0`.
- **Back-pressure.** Hold `out_ready = 0` for 10 cycles after `out_valid`.
  - Outputs stay stable and `in_ready` stays 0 for all 10 cycles.
  - Raising `out_ready` clears `out_valid` and sets `in_ready = 1` on the next edge.
- **Input gaps.** Toggle `in_valid` randomly during a load of A = 9 × 4'h7 and B = 9 × 4'h8.
  - Result is `a_out` = 36'h777777777, `b_out` = 36'h888888888.
  - `cnt` advances only on accepted beats.
- **Resync.** Start a load and assert `in_first` on B beat 4, with data 4'h5.
  - `sync_err` = 1, and that beat becomes A[0], so `a_out[35:32]` = 4'h5.
  - 17 more beats complete the pair correctly.
- **Async reset mid-load.** Pulse `rst_n` low between clock edges after 12 beats.
  - All outputs return to their reset values immediately.
  - A fresh 18-beat load then produces a correct pair.
- **Adder integration.** Connect the loader to the adder and load A = 4'h7 ×9 (+7) and B = 4'h1 ×9 (+1).
  - The adder output is 4'h8 sign-extended, i.e. -8 = 16'hFFF8, per element.
